// File: rtl/posit_mul_seq.sv
// Sequential posit multiplier: decodes two posit operands, multiplies their
// mantissas with a one-bit-per-cycle shift-add loop, then re-encodes the
// product with round-to-nearest-even. Latency is fixed regardless of operands.
module posit_mul_seq #(
    parameter int N  = 16,
    parameter int es = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    output logic [N-1:0] out,
    output logic         inf,
    output logic         zero,
    output logic         done,
    output logic         busy
);

    localparam int M    = N - es;
    localparam int AW   = 2 * M + 2;
    localparam int FW   = 2 * M + 1;
    localparam int BW   = N + es + 2 * M + 1;
    localparam int SMAX = 2 * (N - 2) * (2 ** es) + 2 ** (es + 1);
    localparam int SW   = $clog2(SMAX + 1) + 2;
    localparam int CW   = $clog2(M + 1);
    localparam int MAXS = (N - 2) * (2 ** es);
    localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, DECODE, MUL, PACK, DONE} state_t;

    state_t state, state_nxt;

    logic [N-1:0]          op_a, op_b;
    logic [M:0]            mant_a, mant_b;
    logic signed [SW-1:0]  scale_sum;
    logic                  sign_p, nar_p, zero_p;
    logic [AW-1:0]         acc;
    logic [CW-1:0]         cnt;

    logic signed [SW-1:0]  sc_a, sc_b;
    logic [M:0]            m_a, m_b;

    int                    p_scale, p_k, p_sh;
    logic [FW-1:0]         p_frac;
    logic                  p_rb, p_guard, p_sticky;
    logic [BW-1:0]         p_raw, p_shifted;
    logic [N-2:0]          p_body, p_mag;
    logic [N-1:0]          p_sum, pack_res;

    // Splits a posit into its total scale (regime*2^es + exponent) and a
    // mantissa with hidden bit; the regime run may consume the whole word.
    function automatic void decode(input logic [N-1:0] x,
                                   output logic signed [SW-1:0] sc,
                                   output logic [M:0] mant);
        logic [N-1:0] mag;
        logic [N-2:0] rem;
        logic         rb;
        logic         stop;
        int           run;
        int           k;
        mag  = x[N-1] ? -x : x;
        rb   = mag[N-2];
        run  = 0;
        stop = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            if (!stop && mag[i] == rb) run++;
            else stop = 1'b1;
        end
        k    = rb ? run - 1 : -run;
        rem  = mag[N-2:0] << (run + 1);
        sc   = SW'(k * (2 ** es) + int'(rem[N-2 -: es]));
        mant = {(x != '0), rem[N-es-2:0], 1'b0};
    endfunction

    // Operand field extraction from the captured inputs.
    always_comb begin
        decode(op_a, sc_a, m_a);
        decode(op_b, sc_b, m_b);
    end

    // Normalises the product, builds the regime/exponent/fraction string,
    // rounds it to nearest-even and clamps into [minpos, maxpos].
    always_comb begin
        p_scale   = int'(scale_sum) + (acc[AW-1] ? 1 : 0);
        p_frac    = acc[AW-1] ? acc[AW-2:0] : {acc[AW-3:0], 1'b0};
        p_k       = p_scale >>> es;
        p_rb      = (p_k >= 0);
        p_sh      = p_rb ? p_k : -p_k - 1;
        p_raw     = {p_rb, ~p_rb, p_scale[es-1:0], p_frac, {(N-2){1'b0}}};
        p_shifted = $signed(p_raw) >>> p_sh;
        p_body    = p_shifted[BW-1 -: N-1];
        p_guard   = p_shifted[BW-N];
        p_sticky  = |p_shifted[BW-N-1:0];
        p_sum     = {1'b0, p_body} + {{(N-1){1'b0}}, p_guard & (p_sticky | p_body[0])};
        if (p_scale > MAXS)          p_mag = '1;
        else if (p_scale < -MAXS)    p_mag = {{(N-2){1'b0}}, 1'b1};
        else if (p_sum[N-1])         p_mag = '1;
        else if (p_sum[N-2:0] == '0) p_mag = {{(N-2){1'b0}}, 1'b1};
        else                         p_mag = p_sum[N-2:0];
        pack_res = sign_p ? -{1'b0, p_mag} : {1'b0, p_mag};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state selection plus the busy/done status decoded from state.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = DECODE;
            end
            DECODE: state_nxt = MUL;
            MUL:    if (cnt == CW'(M)) state_nxt = PACK;
            PACK:   state_nxt = DONE;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, decode latch, shift-add loop, result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a      <= '0;
            op_b      <= '0;
            mant_a    <= '0;
            mant_b    <= '0;
            scale_sum <= '0;
            sign_p    <= 1'b0;
            nar_p     <= 1'b0;
            zero_p    <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            out       <= '0;
            inf       <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a <= in1;
                        op_b <= in2;
                    end
                end
                DECODE: begin
                    mant_a    <= m_a;
                    mant_b    <= m_b;
                    scale_sum <= sc_a + sc_b;
                    sign_p    <= op_a[N-1] ^ op_b[N-1];
                    nar_p     <= (op_a == NAR) || (op_b == NAR);
                    zero_p    <= (op_a == '0) || (op_b == '0);
                    acc       <= '0;
                    cnt       <= '0;
                end
                MUL: begin
                    if (mant_b[cnt]) acc <= acc + (AW'(mant_a) << cnt);
                    cnt <= cnt + 1'b1;
                end
                PACK: begin
                    if (nar_p)       out <= NAR;
                    else if (zero_p) out <= '0;
                    else             out <= pack_res;
                    inf  <= nar_p;
                    zero <= !nar_p && zero_p;
                end
                default: ;
            endcase
        end
    end

endmodule
